// File: rtl/updown_pkg.sv
// Shared types for the up/down counter and its wrap tracker.
// Holds the counter width, the event FSM states and the wrap classification.
package updown_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    WAIT_SYNC,
    ARMED,
    PENDING
  } evt_state_e;

  typedef enum logic [1:0] {
    NONE,
    CARRY,
    BORROW,
    RESYNC
  } wrap_kind_e;

endpackage

// File: rtl/updown_wrap_tracker_wrap_detect.sv
// Combinational classifier for one counter step.
// It compares the previous count against the current one under the controls the counter used.
module wrap_detect
  import updown_pkg::*;
(
  input  logic [CNT_W-1:0] prev_count_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic             load_q_i,
  input  logic             control_q_i,
  output wrap_kind_e       kind_o
);

  // A load overrides everything, because the counter jumped to an arbitrary value.
  always_comb begin
    kind_o = NONE;
    if (load_q_i) begin
      kind_o = RESYNC;
    end else if (control_q_i && (prev_count_i == {CNT_W{1'b1}}) && (count_i == '0)) begin
      kind_o = CARRY;
    end else if (!control_q_i && (prev_count_i == '0) && (count_i == {CNT_W{1'b1}})) begin
      kind_o = BORROW;
    end
  end

endmodule

// File: rtl/updown_wrap_tracker.sv
// Extends the 4-bit up/down counter with a high-order word built from observed wraps.
// It also raises a held threshold event through a small valid/ready FSM.
module updown_wrap_tracker
  import updown_pkg::*;
#(
  parameter int                         HI_W   = 8,
  parameter logic [HI_W+CNT_W-1:0]      THRESH = 12'd40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_i,
  input  logic                     control_i,
  input  logic [CNT_W-1:0]         count_i,
  output logic [HI_W+CNT_W-1:0]    ext_count_o,
  output logic                     carry_pulse_o,
  output logic                     borrow_pulse_o,
  output logic                     evt_valid_o,
  input  logic                     evt_ready_i,
  output logic                     evt_overrun_o
);

  localparam int EXT_W = HI_W + CNT_W;

  logic [HI_W-1:0]  hi_q, hi_d;
  logic [CNT_W-1:0] prev_count_q;
  logic             load_q, control_q, prime_q;
  logic [EXT_W-1:0] ext_count_q, ext_count_d;
  logic             carry_q, carry_d, borrow_q, borrow_d;
  logic             evt_valid_q, evt_valid_d, evt_overrun_q, evt_overrun_d;
  logic             hit;
  evt_state_e       state_q, state_d;
  wrap_kind_e       kind;

  wrap_detect u_wrap_detect (
    .prev_count_i (prev_count_q),
    .count_i      (count_i),
    .load_q_i     (load_q),
    .control_q_i  (control_q),
    .kind_o       (kind)
  );

  // The priming edge only records the count; ext_count holds until a valid history exists.
  always_comb begin
    hi_d     = hi_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (prime_q) begin
      case (kind)
        RESYNC: hi_d = '0;
        CARRY: begin
          hi_d    = hi_q + 1'b1;
          carry_d = 1'b1;
        end
        BORROW: begin
          hi_d     = hi_q - 1'b1;
          borrow_d = 1'b1;
        end
        default: hi_d = hi_q;
      endcase
    end
    ext_count_d = prime_q ? {hi_d, count_i} : ext_count_q;
    hit         = prime_q && (ext_count_d == THRESH) && (ext_count_d != ext_count_q);
  end

  // A ready that coincides with a fresh hit completes the old event and re-arms at once.
  always_comb begin
    state_d       = state_q;
    evt_valid_d   = evt_valid_q;
    evt_overrun_d = evt_overrun_q;
    case (state_q)
      WAIT_SYNC: state_d = ARMED;
      ARMED: begin
        if (hit) begin
          evt_valid_d = 1'b1;
          state_d     = PENDING;
        end
      end
      PENDING: begin
        if (evt_ready_i) begin
          if (!hit) begin
            evt_valid_d = 1'b0;
            state_d     = ARMED;
          end
        end else if (hit) begin
          evt_overrun_d = 1'b1;
        end
      end
      default: begin
        state_d     = WAIT_SYNC;
        evt_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q          <= '0;
      prev_count_q  <= '0;
      load_q        <= 1'b0;
      control_q     <= 1'b0;
      prime_q       <= 1'b0;
      ext_count_q   <= '0;
      carry_q       <= 1'b0;
      borrow_q      <= 1'b0;
      evt_valid_q   <= 1'b0;
      evt_overrun_q <= 1'b0;
      state_q       <= WAIT_SYNC;
    end else begin
      hi_q          <= hi_d;
      prev_count_q  <= count_i;
      load_q        <= load_i;
      control_q     <= control_i;
      prime_q       <= 1'b1;
      ext_count_q   <= ext_count_d;
      carry_q       <= carry_d;
      borrow_q      <= borrow_d;
      evt_valid_q   <= evt_valid_d;
      evt_overrun_q <= evt_overrun_d;
      state_q       <= state_d;
    end
  end

  assign ext_count_o    = ext_count_q;
  assign carry_pulse_o  = carry_q;
  assign borrow_pulse_o = borrow_q;
  assign evt_valid_o    = evt_valid_q;
  assign evt_overrun_o  = evt_overrun_q;

endmodule

// File: tb/tb_updown_wrap_tracker.sv
// Directed bench for updown_wrap_tracker: wraps, resync, extension wrap, threshold events and async reset.
// Count values are driven directly as the counter would present them at each edge.
module tb_updown_wrap_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic        control;
  logic [3:0]  count;
  logic [11:0] extCount;
  logic        carryPulse;
  logic        borrowPulse;
  logic        evtValid;
  logic        evtReady;
  logic        evtOverrun;

  int assertCount = 0;
  int failCount   = 0;

  updown_wrap_tracker #(
    .HI_W   (8),
    .THRESH (12'd40)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .load_i         (load),
    .control_i      (control),
    .count_i        (count),
    .ext_count_o    (extCount),
    .carry_pulse_o  (carryPulse),
    .borrow_pulse_o (borrowPulse),
    .evt_valid_o    (evtValid),
    .evt_ready_i    (evtReady),
    .evt_overrun_o  (evtOverrun)
  );

  always #5 clk = ~clk;

  // Drive one edge worth of inputs away from the edge, then settle just after it.
  task automatic applyStimulus(input logic ld, input logic ctl, input logic [3:0] cnt,
                               input logic rdy);
    @(negedge clk);
    load     = ld;
    control  = ctl;
    count    = cnt;
    evtReady = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [11:0] observed,
                             input logic [11:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%03h expected=0x%03h", tag, observed, expected);
    end
  endtask

  initial begin
    rst      = 1'b1;
    load     = 1'b0;
    control  = 1'b0;
    count    = 4'd0;
    evtReady = 1'b0;
    #12;
    $display("[TB] checking reset state");
    checkOutput("rstExt", extCount, 12'h000);
    checkOutput("rstCarry", 12'(carryPulse), 12'h000);
    checkOutput("rstBorrow", 12'(borrowPulse), 12'h000);
    checkOutput("rstValid", 12'(evtValid), 12'h000);
    checkOutput("rstOverrun", 12'(evtOverrun), 12'h000);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] load 1, count up through 15->0");
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd1, 1'b0);
    checkOutput("resyncExt", extCount, 12'h001);
    for (int v = 2; v <= 15; v++) begin
      applyStimulus(1'b0, 1'b1, 4'(v), 1'b0);
      checkOutput("upExt", extCount, 12'(v));
    end
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    checkOutput("carryExt", extCount, 12'h010);
    checkOutput("carryPulse", 12'(carryPulse), 12'h001);
    checkOutput("carryNoBorrow", 12'(borrowPulse), 12'h000);

    $display("[TB] count down through 0->15 twice");
    applyStimulus(1'b0, 1'b0, 4'd15, 1'b0);
    checkOutput("borrowExt", extCount, 12'h00F);
    checkOutput("borrowPulse", 12'(borrowPulse), 12'h001);
    checkOutput("carryOneCycle", 12'(carryPulse), 12'h000);
    for (int v = 14; v >= 0; v--) begin
      applyStimulus(1'b0, 1'b0, 4'(v), 1'b0);
      checkOutput("downExt", extCount, 12'(v));
    end
    checkOutput("borrowOneCycle", 12'(borrowPulse), 12'h000);
    applyStimulus(1'b0, 1'b1, 4'd15, 1'b0);
    checkOutput("hiUnderflowExt", extCount, 12'hFFF);
    checkOutput("hiUnderflowBorrow", 12'(borrowPulse), 12'h001);
    applyStimulus(1'b0, 1'b1, 4'd0, 1'b0);
    checkOutput("hiOverflowExt", extCount, 12'h000);
    checkOutput("hiOverflowCarry", 12'(carryPulse), 12'h001);

    $display("[TB] climb to 0x023 then load 13");
    for (int e = 1; e <= 12'h022; e++) begin
      applyStimulus(1'b0, 1'b1, 4'(e), 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 4'd3, 1'b0);
    checkOutput("preLoadExt", extCount, 12'h023);
    checkOutput("preLoadValid", 12'(evtValid), 12'h000);
    applyStimulus(1'b0, 1'b1, 4'd13, 1'b0);
    checkOutput("loadExt", extCount, 12'h00D);
    checkOutput("loadNoCarry", 12'(carryPulse), 12'h000);
    checkOutput("loadNoBorrow", 12'(borrowPulse), 12'h000);

    $display("[TB] count up to threshold 40");
    for (int e = 12'h00E; e <= 12'h028; e++) begin
      applyStimulus(1'b0, 1'b1, 4'(e), 1'b0);
      checkOutput("threshExt", extCount, 12'(e));
      checkOutput("threshValid", 12'(evtValid), (e == 12'h028) ? 12'h001 : 12'h000);
    end
    applyStimulus(1'b0, 1'b1, 4'd8, 1'b0);
    checkOutput("heldValid", 12'(evtValid), 12'h001);
    applyStimulus(1'b0, 1'b1, 4'd8, 1'b1);
    checkOutput("ackValid", 12'(evtValid), 12'h000);
    checkOutput("ackOverrun", 12'(evtOverrun), 12'h000);
    applyStimulus(1'b0, 1'b0, 4'd8, 1'b0);
    checkOutput("dwellValid", 12'(evtValid), 12'h000);

    $display("[TB] re-entry, simultaneous ack, overrun");
    applyStimulus(1'b0, 1'b1, 4'd7, 1'b0);
    checkOutput("leaveExt", extCount, 12'h027);
    applyStimulus(1'b0, 1'b0, 4'd8, 1'b0);
    checkOutput("reenterValid", 12'(evtValid), 12'h001);
    applyStimulus(1'b0, 1'b1, 4'd7, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd8, 1'b1);
    checkOutput("ackHitValid", 12'(evtValid), 12'h001);
    checkOutput("ackHitOverrun", 12'(evtOverrun), 12'h000);
    applyStimulus(1'b0, 1'b0, 4'd7, 1'b0);
    checkOutput("ackHitStillPending", 12'(evtValid), 12'h001);
    applyStimulus(1'b0, 1'b1, 4'd8, 1'b0);
    checkOutput("overrunSet", 12'(evtOverrun), 12'h001);
    checkOutput("overrunValid", 12'(evtValid), 12'h001);
    applyStimulus(1'b0, 1'b1, 4'd9, 1'b0);
    checkOutput("overrunSticky", 12'(evtOverrun), 12'h001);
    checkOutput("pastThreshExt", extCount, 12'h029);

    $display("[TB] asynchronous reset while pending");
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("asyncValid", 12'(evtValid), 12'h000);
    checkOutput("asyncOverrun", 12'(evtOverrun), 12'h000);
    checkOutput("asyncExt", extCount, 12'h000);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] priming edge does not detect wraps");
    applyStimulus(1'b0, 1'b1, 4'd15, 1'b0);
    checkOutput("primeNoBorrow", 12'(borrowPulse), 12'h000);
    checkOutput("primeNoValid", 12'(evtValid), 12'h000);
    applyStimulus(1'b0, 1'b1, 4'd0, 1'b0);
    checkOutput("postPrimeExt", extCount, 12'h010);
    checkOutput("postPrimeCarry", 12'(carryPulse), 12'h001);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
